led_peak_meter: RTL and testbench
=================================

LED_PEAK_METER -- requirements
Module: led_peak_meter

Interface
REQ-001 The block SHALL have parameter W, default 16, meaning sample width in bits.
REQ-002 The block SHALL have parameter DECAY_SHIFT, default 4, meaning the peak decay rate: the peak loses 1/2^DECAY_SHIFT of its value per sample.
REQ-003 The block SHALL have parameter HOLD_SAMPLES, default 2400, meaning the number of samples a new peak is held before decay starts.
REQ-004 The block SHALL have port clk_256fs, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port strobe, input, 1 bit, a one-cycle pulse that marks in0..in7 valid.
REQ-007 The block SHALL have ports in0..in7, input, signed W bits each: calibrated samples, in0..in3 from the input jacks and in4..in7 from the DAC outputs.
REQ-008 The block SHALL have ports led0..led7, output, signed 8 bits each: signed peak level per channel, fed to the LED driver led0..led7.
REQ-009 The block SHALL have port busy, output, 1 bit, high while a sample set is being processed.
REQ-010 The block SHALL have port overrun, output, 1 bit, a sticky flag that is set when a strobe arrives while busy.

Function
REQ-011 The block SHALL use a state machine with states IDLE, PROC and UPDATE.
REQ-012 In IDLE, a strobe SHALL latch in0..in7 into an internal snapshot, clear the channel index to 0 and move to PROC.
REQ-013 PROC SHALL process one channel per cycle, indices 0 to 7, and SHALL move to UPDATE after index 7.
REQ-014 UPDATE SHALL write all of led0..led7 in the same cycle and return to IDLE.
REQ-015 busy SHALL be 1 in PROC and UPDATE and 0 in IDLE.
REQ-016 led outputs SHALL change exactly 10 cycles after the strobe cycle (latch, 8 PROC cycles, UPDATE).
REQ-017 Per-channel magnitude a SHALL be |x|, saturated so that x = -2^(W-1) gives a = 2^(W-1)-1; a is W-1 bits wide.
REQ-018 Per-channel state SHALL be: peak (W-1 bits, unsigned), sgn (1 bit), hold (a counter wide enough for HOLD_SAMPLES).
REQ-019 If a >= peak, the channel SHALL set peak=a, sgn=(x<0) and hold=HOLD_SAMPLES.
REQ-020 Else if hold > 0, the channel SHALL decrement hold and leave peak unchanged.
REQ-021 Else, if peak>>DECAY_SHIFT is nonzero, the channel SHALL set peak = peak - (peak>>DECAY_SHIFT).
REQ-022 Else, if peak is nonzero, the channel SHALL set peak = peak - 1; peak SHALL never underflow below 0.
REQ-023 On a tie (a == peak), REQ-019 SHALL apply: hold reloads and sgn takes the new sample's sign.
REQ-024 In UPDATE, each channel SHALL compute m = peak[W-2:W-8] (7 bits, 0..127) and output led = sgn ? -m : +m, range -127..+127.
REQ-025 When m = 0, led SHALL be 0 regardless of sgn.
REQ-026 A strobe in PROC or UPDATE SHALL be ignored (no snapshot, no restart) and SHALL set overrun=1.
REQ-027 overrun SHALL be cleared only by reset.
REQ-028 A strobe in the same cycle that UPDATE returns to IDLE SHALL be treated as an overrun.
REQ-029 A strobe in the first IDLE cycle after UPDATE SHALL be accepted normally.
REQ-030 Processing SHALL use only the latched snapshot; changes on in0..in7 during PROC SHALL have no effect.

Reset
REQ-031 While rst=0, the block SHALL asynchronously force state=IDLE, channel index=0, all peak/sgn/hold=0, led0..led7=0, busy=0 and overrun=0.
REQ-032 Assertion of rst mid-PROC SHALL abandon the sample set; no partial led update SHALL occur after release.
REQ-033 The first strobe after rst release SHALL be accepted.

Verification
(W=16, DECAY_SHIFT=4, HOLD_SAMPLES=3 for scenarios 3-4.)
REQ-034 Release reset, no strobe -> led0..7=0, busy=0, overrun=0 indefinitely.
REQ-035 in0=16384, others 0, one strobe -> busy high for cycles 1..9; at cycle 10 led0=+64 and all others 0.
REQ-036 in5=-32768, one strobe -> led5=-127 (0x81); a following strobe with in5=+32767 (tie) -> led5=+127.
REQ-037 Peak 16384 on in2, then zero strobes -> led2=64 after strobes 1-3; after strobe 4 peak=15360 and led2=60; after the next strobe peak=14400 and led2=56.
REQ-038 Peak 8 (m=0) with hold expired -> peak decrements by 1 per strobe to 0, then stays 0 without wrapping.
REQ-039 Second strobe 4 cycles after the first -> overrun=1 and stays 1; first set completes at cycle 10 with correct values; rst pulsed at cycle 5 of a later set -> led all 0 immediately and no update after release.

Source files
------------

// File: rtl/led_peak_meter.sv
// led_peak_meter: eight-channel peak meter with hold and exponential decay.
// One strobe snapshots all channels. The channels are then updated one per
// cycle and the LED levels are published together in a single cycle.
module led_peak_meter #(
  parameter int unsigned W            = 16,
  parameter int unsigned DECAY_SHIFT  = 4,
  parameter int unsigned HOLD_SAMPLES = 2400
) (
  input  logic                clk_256fs,
  input  logic                rst,
  input  logic                strobe,
  input  logic signed [W-1:0] in0,
  input  logic signed [W-1:0] in1,
  input  logic signed [W-1:0] in2,
  input  logic signed [W-1:0] in3,
  input  logic signed [W-1:0] in4,
  input  logic signed [W-1:0] in5,
  input  logic signed [W-1:0] in6,
  input  logic signed [W-1:0] in7,
  output logic signed [7:0]   led0,
  output logic signed [7:0]   led1,
  output logic signed [7:0]   led2,
  output logic signed [7:0]   led3,
  output logic signed [7:0]   led4,
  output logic signed [7:0]   led5,
  output logic signed [7:0]   led6,
  output logic signed [7:0]   led7,
  output logic                busy,
  output logic                overrun
);

  localparam int unsigned NCH = 8;
  localparam int unsigned PW  = W - 1;
  localparam int unsigned HW  = (HOLD_SAMPLES < 1) ? 1 : $clog2(HOLD_SAMPLES + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_SAMPLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PROC   = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t              r_state;
  logic [2:0]          r_idx;
  logic signed [W-1:0] r_snap [NCH];
  logic [PW-1:0]       r_peak [NCH];
  logic                r_sgn  [NCH];
  logic [HW-1:0]       r_hold [NCH];
  logic signed [7:0]   r_led  [NCH];
  logic                r_busy;
  logic                r_overrun;

  logic signed [W-1:0] w_in [NCH];
  logic signed [W-1:0] w_x;
  logic [PW-1:0]       w_a;
  logic [PW-1:0]       w_cur_peak;
  logic [HW-1:0]       w_cur_hold;
  logic                w_cur_sgn;
  logic [PW-1:0]       w_shr;
  logic [PW-1:0]       w_peak_nxt;
  logic [HW-1:0]       w_hold_nxt;
  logic                w_sgn_nxt;
  logic [7:0]          w_mag [NCH];
  logic signed [7:0]   w_led [NCH];

  assign w_in[0] = in0;
  assign w_in[1] = in1;
  assign w_in[2] = in2;
  assign w_in[3] = in3;
  assign w_in[4] = in4;
  assign w_in[5] = in5;
  assign w_in[6] = in6;
  assign w_in[7] = in7;

  assign led0    = r_led[0];
  assign led1    = r_led[1];
  assign led2    = r_led[2];
  assign led3    = r_led[3];
  assign led4    = r_led[4];
  assign led5    = r_led[5];
  assign led6    = r_led[6];
  assign led7    = r_led[7];
  assign busy    = r_busy;
  assign overrun = r_overrun;

  // Next peak/sign/hold for the channel currently selected by r_idx
  always_comb begin
    w_x        = r_snap[r_idx];
    w_cur_peak = r_peak[r_idx];
    w_cur_hold = r_hold[r_idx];
    w_cur_sgn  = r_sgn[r_idx];
    w_peak_nxt = w_cur_peak;
    w_hold_nxt = w_cur_hold;
    w_sgn_nxt  = w_cur_sgn;

    // |x| computed on the low W-1 bits; the most negative code saturates
    if (w_x[W-1]) begin
      if (w_x[PW-1:0] == '0) begin
        w_a = '1;
      end else begin
        w_a = PW'(~w_x[PW-1:0] + PW'(1));
      end
    end else begin
      w_a = w_x[PW-1:0];
    end

    w_shr = w_cur_peak >> DECAY_SHIFT;

    if (w_a >= w_cur_peak) begin
      w_peak_nxt = w_a;
      w_sgn_nxt  = w_x[W-1];
      w_hold_nxt = HOLD_INIT;
    end else if (w_cur_hold != '0) begin
      w_hold_nxt = w_cur_hold - HW'(1);
    end else if (w_shr != '0) begin
      w_peak_nxt = w_cur_peak - w_shr;
    end else if (w_cur_peak != '0) begin
      w_peak_nxt = w_cur_peak - PW'(1);
    end
  end

  // Signed LED level for every channel from the top 7 peak bits
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_mag[i] = {1'b0, r_peak[i][PW-1:PW-7]};
      w_led[i] = r_sgn[i] ? $signed(8'(~w_mag[i] + 8'd1)) : $signed(w_mag[i]);
    end
  end

  // Control FSM with snapshot, per-channel state and registered outputs
  always_ff @(posedge clk_256fs or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_idx     <= 3'd0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        r_snap[i] <= '0;
        r_peak[i] <= '0;
        r_sgn[i]  <= 1'b0;
        r_hold[i] <= '0;
        r_led[i]  <= '0;
      end
    end else begin
      if (strobe && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (strobe) begin
            for (int i = 0; i < NCH; i++) begin
              r_snap[i] <= w_in[i];
            end
            r_idx   <= 3'd0;
            r_state <= S_PROC;
            r_busy  <= 1'b1;
          end
        end
        S_PROC: begin
          r_peak[r_idx] <= w_peak_nxt;
          r_sgn[r_idx]  <= w_sgn_nxt;
          r_hold[r_idx] <= w_hold_nxt;
          r_idx         <= r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            r_state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          for (int i = 0; i < NCH; i++) begin
            r_led[i] <= w_led[i];
          end
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_peak_meter.sv
// Directed bench for led_peak_meter (W=16, DECAY_SHIFT=4, HOLD_SAMPLES=3).
module tb_led_peak_meter;

  logic               clk;
  logic               rst;
  logic               strobe;
  logic signed [15:0] in_v  [8];
  logic signed [7:0]  led_v [8];
  logic               busy;
  logic               overrun;

  int total = 0;
  int bad   = 0;

  led_peak_meter #(.W(16), .DECAY_SHIFT(4), .HOLD_SAMPLES(3)) dut (
    .clk_256fs(clk), .rst(rst), .strobe(strobe),
    .in0(in_v[0]), .in1(in_v[1]), .in2(in_v[2]), .in3(in_v[3]),
    .in4(in_v[4]), .in5(in_v[5]), .in6(in_v[6]), .in7(in_v[7]),
    .led0(led_v[0]), .led1(led_v[1]), .led2(led_v[2]), .led3(led_v[3]),
    .led4(led_v[4]), .led5(led_v[5]), .led6(led_v[6]), .led7(led_v[7]),
    .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 8; i++) in_v[i] = 16'sd0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    strobe = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Strobe with current inputs, clear inputs, end in cycle 10 after the strobe
  task automatic run_set();
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    clear_inputs();
    repeat (9) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    strobe = 1'b0;
    clear_inputs();
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (led_v[i] !== 8'sd0) begin
        bad++;
        $display("FAIL reset_held led%0d got=%0d exp=0", i, led_v[i]);
      end
    end
    total++;
    if (busy !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_held flags got busy=%b overrun=%b exp 0 0", busy, overrun);
    end
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      total++;
      if (busy !== 1'b0 || overrun !== 1'b0 || led_v[0] !== 8'sd0 || led_v[7] !== 8'sd0) begin
        bad++;
        $display("FAIL reset_idle cycle%0d got busy=%b overrun=%b led0=%0d led7=%0d exp all 0",
                 c, busy, overrun, led_v[0], led_v[7]);
      end
    end
  endtask

  task automatic test_single();
    apply_reset();
    in_v[0] = 16'sd16384;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    in_v[0] = 16'sd0;
    for (int k = 1; k <= 9; k++) begin
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL single_busy cycle%0d got=%b exp=1", k, busy);
      end
      if (k == 9) begin
        total++;
        if (led_v[0] !== 8'sd0) begin
          bad++;
          $display("FAIL single_early led0 cycle9 got=%0d exp=0", led_v[0]);
        end
      end
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      logic signed [7:0] exp_led;
      exp_led = (i == 0) ? 8'sd64 : 8'sd0;
      total++;
      if (led_v[i] !== exp_led) begin
        bad++;
        $display("FAIL single led%0d got=%0d exp=%0d", i, led_v[i], exp_led);
      end
    end
    total++;
    if (busy !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL single_done got busy=%b overrun=%b exp 0 0", busy, overrun);
    end
  endtask

  task automatic test_neg_sat_tie();
    apply_reset();
    in_v[5] = -16'sd32768;
    run_set();
    total++;
    if (led_v[5] !== -8'sd127) begin
      bad++;
      $display("FAIL neg_sat led5 got=%0d exp=-127", led_v[5]);
    end
    in_v[5] = 16'sd32767;
    run_set();
    total++;
    if (led_v[5] !== 8'sd127) begin
      bad++;
      $display("FAIL tie_sign led5 got=%0d exp=127", led_v[5]);
    end
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL neg_sat_overrun got=%b exp=0", overrun);
    end
  endtask

  task automatic test_hold_decay();
    logic signed [7:0] exp_led;
    logic [14:0]       exp_peak;
    apply_reset();
    in_v[2] = 16'sd16384;
    run_set();
    total++;
    if (led_v[2] !== 8'sd64) begin
      bad++;
      $display("FAIL hold_peak led2 got=%0d exp=64", led_v[2]);
    end
    for (int s = 1; s <= 5; s++) begin
      run_set();
      case (s)
        4:       begin exp_led = 8'sd60; exp_peak = 15'd15360; end
        5:       begin exp_led = 8'sd56; exp_peak = 15'd14400; end
        default: begin exp_led = 8'sd64; exp_peak = 15'd16384; end
      endcase
      total++;
      if (led_v[2] !== exp_led) begin
        bad++;
        $display("FAIL hold_decay strobe%0d led2 got=%0d exp=%0d", s, led_v[2], exp_led);
      end
      total++;
      if (dut.r_peak[2] !== exp_peak) begin
        bad++;
        $display("FAIL hold_decay strobe%0d peak got=%0d exp=%0d", s, dut.r_peak[2], exp_peak);
      end
    end
  endtask

  task automatic test_small_decay();
    logic [14:0] exp_peak;
    apply_reset();
    in_v[3] = 16'sd8;
    run_set();
    total++;
    if (dut.r_peak[3] !== 15'd8) begin
      bad++;
      $display("FAIL small_load peak got=%0d exp=8", dut.r_peak[3]);
    end
    for (int s = 1; s <= 14; s++) begin
      run_set();
      if (s <= 3)           exp_peak = 15'd8;
      else if (s - 3 >= 8)  exp_peak = 15'd0;
      else                  exp_peak = 15'(8 - (s - 3));
      total++;
      if (dut.r_peak[3] !== exp_peak) begin
        bad++;
        $display("FAIL small_decay strobe%0d peak got=%0d exp=%0d", s, dut.r_peak[3], exp_peak);
      end
      total++;
      if (led_v[3] !== 8'sd0) begin
        bad++;
        $display("FAIL small_decay strobe%0d led3 got=%0d exp=0", s, led_v[3]);
      end
    end
  endtask

  task automatic test_snapshot();
    apply_reset();
    in_v[1] = -16'sd12800;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    for (int i = 0; i < 8; i++) in_v[i] = 16'sd32767;
    repeat (9) tick();
    total++;
    if (led_v[1] !== -8'sd50) begin
      bad++;
      $display("FAIL snapshot led1 got=%0d exp=-50", led_v[1]);
    end
    total++;
    if (led_v[0] !== 8'sd0 || led_v[7] !== 8'sd0) begin
      bad++;
      $display("FAIL snapshot others got led0=%0d led7=%0d exp 0 0", led_v[0], led_v[7]);
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    in_v[4] = 16'sd8192;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    clear_inputs();
    repeat (8) tick();
    total++;
    if (overrun !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_cycle9 got overrun=%b busy=%b exp 0 1", overrun, busy);
    end
    // strobe during UPDATE is an overrun, strobe in the next IDLE cycle is accepted
    in_v[4] = 16'sd32767;
    strobe = 1'b1;
    tick();
    in_v[4] = 16'sd25600;
    total++;
    if (overrun !== 1'b1 || busy !== 1'b0 || led_v[4] !== 8'sd32) begin
      bad++;
      $display("FAIL b2b_cycle10 got overrun=%b busy=%b led4=%0d exp 1 0 32", overrun, busy, led_v[4]);
    end
    tick();
    strobe = 1'b0;
    clear_inputs();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept busy got=%b exp=1", busy);
    end
    repeat (9) tick();
    total++;
    if (led_v[4] !== 8'sd100 || overrun !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second led4 got=%0d overrun=%b exp 100 1", led_v[4], overrun);
    end
  endtask

  task automatic test_overrun_reset();
    apply_reset();
    in_v[6] = 16'sd16384;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    clear_inputs();
    repeat (3) tick();
    in_v[6] = 16'sd32767;
    in_v[7] = 16'sd32767;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    clear_inputs();
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL ovr_set got=%b exp=1", overrun);
    end
    repeat (5) tick();
    total++;
    if (led_v[6] !== 8'sd64 || led_v[7] !== 8'sd0) begin
      bad++;
      $display("FAIL ovr_first_set got led6=%0d led7=%0d exp 64 0", led_v[6], led_v[7]);
    end
    repeat (5) tick();
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL ovr_sticky got=%b exp=1", overrun);
    end
    // abandon a later set with reset at cycle 5
    in_v[6] = 16'sd32767;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    clear_inputs();
    repeat (4) tick();
    rst = 1'b0;
    #1;
    total++;
    if (led_v[6] !== 8'sd0 || busy !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL ovr_async_rst got led6=%0d busy=%b overrun=%b exp 0 0 0", led_v[6], busy, overrun);
    end
    tick();
    rst = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      total++;
      if (led_v[6] !== 8'sd0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL ovr_no_update cycle%0d got led6=%0d busy=%b exp 0 0", c, led_v[6], busy);
      end
    end
    in_v[7] = -16'sd16384;
    run_set();
    total++;
    if (led_v[7] !== -8'sd64 || led_v[6] !== 8'sd0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL ovr_after_rst got led7=%0d led6=%0d overrun=%b exp -64 0 0",
               led_v[7], led_v[6], overrun);
    end
  endtask

  initial begin
    rst = 1'b0;
    strobe = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_neg_sat_tie();
    test_hold_decay();
    test_small_decay();
    test_snapshot();
    test_back_to_back();
    test_overrun_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
